// File: rtl/busrq_sequencer.sv
// busrq_sequencer: bus-request handshake stage.
// Synchronises the BUSRQ pin, tracks the CBUSRQ flag, grants the bus on a
// machine-cycle boundary, drives BUSAK / bus_float / halt_pipe, and returns
// not_enable_busrq to the op-head decoder.
// Optional build macro BUSRQ_HOLD_COUNT_EN adds the hold_count output
// (number of cycles spent in ACK, saturating).
module busrq_sequencer #(
  parameter int SYNC_STAGES    = 2,  // 1..3
  parameter int RELEASE_CYCLES = 1   // 1..7
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BUSRQ,
  input  logic        M_CYCLE_END,
  input  logic        P2_Set_CBUSRQ,
  input  logic        inhibit_busrq,
  output logic        BUSRQ_sync,
  output logic        not_enable_busrq,
  output logic        CBUSRQ,
  output logic        BUSAK,
  output logic        bus_float,
  output logic        halt_pipe,
  output logic [1:0]  state_o
`ifdef BUSRQ_HOLD_COUNT_EN
  ,
  output logic [15:0] hold_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0]             rel_cnt_q, rel_cnt_d;
  logic                   cbusrq_d, busak_d, float_d, halt_d, neb_d;

  // Pin synchroniser chain; idles high (request deasserted).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= BUSRQ;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign BUSRQ_sync = sync_q[SYNC_STAGES-1];
  assign state_o    = state_q;

  // State and registered-output update.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q          <= ST_IDLE;
      rel_cnt_q        <= 3'd0;
      CBUSRQ           <= 1'b0;
      BUSAK            <= 1'b1;
      bus_float        <= 1'b0;
      halt_pipe        <= 1'b0;
      not_enable_busrq <= 1'b1;
    end else begin
      state_q          <= state_d;
      rel_cnt_q        <= rel_cnt_d;
      CBUSRQ           <= cbusrq_d;
      BUSAK            <= busak_d;
      bus_float        <= float_d;
      halt_pipe        <= halt_d;
      not_enable_busrq <= neb_d;
    end
  end

  // Next-state and next-output decode; every output is held unless a
  // transition changes it, so all outputs stay purely registered.
  always_comb begin
    state_d   = state_q;
    rel_cnt_d = rel_cnt_q;
    cbusrq_d  = CBUSRQ;
    busak_d   = BUSAK;
    float_d   = bus_float;
    halt_d    = halt_pipe;
    case (state_q)
      ST_IDLE: begin
        // inhibit also blocks directly, so a request arriving in the same
        // cycle as inhibit rises is not accepted through the stale gate.
        if (P2_Set_CBUSRQ && !not_enable_busrq && !inhibit_busrq) begin
          state_d  = ST_PENDING;
          cbusrq_d = 1'b1;
        end
      end
      ST_PENDING: begin
        if (BUSRQ_sync) begin
          state_d  = ST_IDLE;
          cbusrq_d = 1'b0;
        end else if (M_CYCLE_END) begin
          state_d = ST_ACK;
          busak_d = 1'b0;
          float_d = 1'b1;
          halt_d  = 1'b1;
        end
      end
      ST_ACK: begin
        if (BUSRQ_sync) begin
          state_d   = ST_RELEASE;
          busak_d   = 1'b1;
          rel_cnt_d = 3'(RELEASE_CYCLES);
        end
      end
      ST_RELEASE: begin
        // Bus stays floated during turnaround; a fresh pin request here is
        // dropped and must come back via P2_Set_CBUSRQ.
        if (rel_cnt_q <= 3'd1) begin
          state_d   = ST_IDLE;
          rel_cnt_d = 3'd0;
          float_d   = 1'b0;
          halt_d    = 1'b0;
          cbusrq_d  = 1'b0;
        end else begin
          rel_cnt_d = rel_cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    neb_d = (state_d != ST_IDLE) | inhibit_busrq;
  end

`ifdef BUSRQ_HOLD_COUNT_EN
  // Cycles spent holding the bus; restarts on each grant, saturates.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hold_count <= 16'd0;
    end else if (state_q == ST_PENDING && state_d == ST_ACK) begin
      hold_count <= 16'd0;
    end else if (state_q == ST_ACK && hold_count != 16'hFFFF) begin
      hold_count <= hold_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_busrq_sequencer.sv
// tb_busrq_sequencer: scoreboard bench. Stimulus pushes cycle-stamped expected
// output vectors; a negedge monitor pops and compares them. Two instances
// share inputs: RELEASE_CYCLES = 1 (dut1) and RELEASE_CYCLES = 3 (dut3).
// Vector layout: {BUSRQ_sync, not_enable_busrq, CBUSRQ, BUSAK, bus_float,
// halt_pipe, state[1:0]}.
module tb_busrq_sequencer;

  logic clk = 1'b0;
  logic rst_n, busrq, mce, p2, inh;

  logic       sy1, ne1, cb1, ak1, fl1, hp1;
  logic [1:0] st1;
  logic       sy3, ne3, cb3, ak3, fl3, hp3;
  logic [1:0] st3;
`ifdef BUSRQ_HOLD_COUNT_EN
  logic [15:0] hc1, hc3;
`endif

  busrq_sequencer #(.SYNC_STAGES(2), .RELEASE_CYCLES(1)) dut1 (
    .CLK(clk), .RESET(rst_n), .BUSRQ(busrq), .M_CYCLE_END(mce),
    .P2_Set_CBUSRQ(p2), .inhibit_busrq(inh),
    .BUSRQ_sync(sy1), .not_enable_busrq(ne1), .CBUSRQ(cb1), .BUSAK(ak1),
    .bus_float(fl1), .halt_pipe(hp1), .state_o(st1)
`ifdef BUSRQ_HOLD_COUNT_EN
    , .hold_count(hc1)
`endif
  );

  busrq_sequencer #(.SYNC_STAGES(2), .RELEASE_CYCLES(3)) dut3 (
    .CLK(clk), .RESET(rst_n), .BUSRQ(busrq), .M_CYCLE_END(mce),
    .P2_Set_CBUSRQ(p2), .inhibit_busrq(inh),
    .BUSRQ_sync(sy3), .not_enable_busrq(ne3), .CBUSRQ(cb3), .BUSAK(ak3),
    .bus_float(fl3), .halt_pipe(hp3), .state_o(st3)
`ifdef BUSRQ_HOLD_COUNT_EN
    , .hold_count(hc3)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    logic [1:0]  sel;   // bit0 dut1, bit1 dut3
    logic [7:0]  v;
    bit          hck;   // check dut1 hold_count (macro builds only)
    logic [15:0] hc;
  } exp_t;

  exp_t q[$];
  int   base;
  int   checks = 0;
  int   errors = 0;

  localparam logic [7:0] V_RST  = 8'b1101_0000;
  localparam logic [7:0] V_IDL  = 8'b1001_0000;  // idle, pin high
  localparam logic [7:0] V_IDL0 = 8'b0001_0000;  // idle, pin low
  localparam logic [7:0] V_PEN  = 8'b0111_0001;
  localparam logic [7:0] V_PEN1 = 8'b1111_0001;  // pending, withdrawn
  localparam logic [7:0] V_ACK  = 8'b0110_1110;
  localparam logic [7:0] V_ACK1 = 8'b1110_1110;  // ack, pin released
  localparam logic [7:0] V_REL  = 8'b1111_1111;
  localparam logic [7:0] V_REL0 = 8'b0111_1111;  // release, pin low again

  task automatic ex(input int k, input logic [1:0] sel, input logic [7:0] v,
                    input bit hck = 1'b0, input logic [15:0] hc = 16'd0);
    exp_t e;
    e.cyc = base + k; e.sel = sel; e.v = v; e.hck = hck; e.hc = hc;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int c, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", nm, c, act, req);
    end
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        checks++; errors++;
        $display("FAIL stale_entry cyc=%0d actual=%0d required=%0d", cyc, cyc, e.cyc);
      end else begin
        if (e.sel[0]) chk("dut1_out", e.cyc, {8'd0, sy1, ne1, cb1, ak1, fl1, hp1, st1}, {8'd0, e.v});
        if (e.sel[1]) chk("dut3_out", e.cyc, {8'd0, sy3, ne3, cb3, ak3, fl3, hp3, st3}, {8'd0, e.v});
`ifdef BUSRQ_HOLD_COUNT_EN
        if (e.hck) chk("dut1_hold_count", e.cyc, hc1, e.hc);
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b0; busrq = 1'b1; mce = 1'b0; p2 = 1'b0; inh = 1'b0;

    // Reset, then ten idle cycles with the pin high.
    tick(2);
    base = cyc;
    ex(0, 2'b11, V_RST, 1'b1, 16'd0);
    ex(1, 2'b11, V_RST);
    for (int k = 2; k <= 11; k++) ex(k, 2'b11, V_IDL);
    tick(1); rst_n = 1'b1;
    tick(10);

    // Full grant: request, grant at M_CYCLE_END, hold 20 cycles, release.
    base = cyc;
    ex(1, 2'b11, V_IDL);
    ex(2, 2'b11, V_IDL0);
    ex(3, 2'b11, V_PEN);
    ex(5, 2'b11, V_PEN);
    ex(6, 2'b11, V_ACK, 1'b1, 16'd0);
    ex(7, 2'b01, V_ACK, 1'b1, 16'd1);
    ex(24, 2'b11, V_ACK);
    ex(25, 2'b11, V_ACK1);
    ex(26, 2'b11, V_REL);
    ex(27, 2'b01, V_IDL, 1'b1, 16'd20);
    ex(27, 2'b10, V_REL);
    ex(28, 2'b10, V_REL);
    ex(29, 2'b11, V_IDL);
    busrq = 1'b0;
    tick(2);  p2 = 1'b1;
    tick(1);  p2 = 1'b0;
    tick(2);  mce = 1'b1;
    tick(1);  mce = 1'b0;
    tick(17); busrq = 1'b1;
    tick(7);

    // Withdrawal in PENDING, colliding with M_CYCLE_END.
    base = cyc;
    ex(2, 2'b11, V_IDL0);
    ex(3, 2'b11, V_PEN);
    ex(5, 2'b11, V_PEN1);
    ex(6, 2'b11, V_IDL);
    ex(7, 2'b11, V_IDL);
    busrq = 1'b0;
    tick(2); p2 = 1'b1;
    tick(1); p2 = 1'b0; busrq = 1'b1;
    tick(2); mce = 1'b1;
    tick(1); mce = 1'b0;
    tick(2);

    // inhibit together with the request: blocked, then gate reopens.
    base = cyc;
    ex(2, 2'b11, V_IDL0);
    ex(3, 2'b11, 8'b0101_0000);
    ex(4, 2'b11, 8'b0101_0000);
    ex(5, 2'b11, V_IDL0);
    ex(6, 2'b11, V_IDL0);
    ex(8, 2'b11, V_IDL);
    busrq = 1'b0;
    tick(2); p2 = 1'b1; inh = 1'b1;
    tick(2); p2 = 1'b0; inh = 1'b0;
    tick(1); busrq = 1'b1;
    tick(3);

    // Same-cycle M_CYCLE_END not granted; re-request during RELEASE dropped;
    // then a fresh grant and an asynchronous reset while in ACK.
    base = cyc;
    ex(2, 2'b11, V_IDL0);
    ex(3, 2'b11, V_PEN);
    ex(4, 2'b11, V_PEN);
    ex(5, 2'b11, V_ACK, 1'b1, 16'd0);
    ex(8, 2'b11, V_ACK1);
    ex(9, 2'b11, V_REL);
    ex(10, 2'b01, V_IDL0, 1'b1, 16'd4);
    ex(10, 2'b10, V_REL0);
    ex(11, 2'b10, V_REL0);
    ex(12, 2'b11, V_IDL0);
    ex(14, 2'b11, V_IDL0);
    ex(15, 2'b11, V_PEN);
    ex(16, 2'b11, V_ACK);
    ex(17, 2'b11, V_RST, 1'b1, 16'd0);
    busrq = 1'b0;
    tick(2); p2 = 1'b1; mce = 1'b1;
    tick(1); p2 = 1'b0; mce = 1'b0;
    tick(1); mce = 1'b1;
    tick(1); mce = 1'b0;
    tick(1); busrq = 1'b1;
    tick(2); busrq = 1'b0;
    tick(6); p2 = 1'b1;
    tick(1); p2 = 1'b0; mce = 1'b1;
    tick(1); mce = 1'b0;
    tick(1); #2 rst_n = 1'b0;
    tick(2); rst_n = 1'b1; busrq = 1'b1;

    for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
    end
    tick(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
